// File: rtl/ciclo_esclavo_pkg.sv
// Shared definitions for the ciclo step-bus consumer: FSM states and bus timing.
package ciclo_esclavo_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARRANQUE  = 2'd1,
      CORRIENDO = 2'd2,
      FIN       = 2'd3
   } estado_t;

   localparam int unsigned TIEMPO       = 32;
   localparam int unsigned DURACION_MIN = 2;

endpackage

// File: rtl/ciclo_esclavo_detector_paso.sv
// Step detector: remembers the last accepted ciclo and classifies the current one
// as a legal increment, a legal wrap, or a protocol violation.
module detector_paso
   import ciclo_esclavo_pkg::*;
#(
   parameter int unsigned W_CICLO = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               limpiar,
   input  logic               cargar,
   input  logic [W_CICLO-1:0] ciclo,
   input  logic [W_CICLO-1:0] duracion,
   output logic               incremento,
   output logic               wrap,
   output logic               violacion
);

   logic [W_CICLO-1:0] ciclo_prev;
   logic [W_CICLO:0]   prev_mas_uno;
   logic               cambio;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ciclo_prev <= '0;
      else if (limpiar)
         ciclo_prev <= '0;
      else if (cargar)
         ciclo_prev <= ciclo;
   end

   // One extra bit keeps 63 -> 0 from looking like an increment.
   always_comb begin
      prev_mas_uno = {1'b0, ciclo_prev} + 1'b1;
      cambio       = (ciclo != ciclo_prev);
      incremento   = ({1'b0, ciclo} == prev_mas_uno) && (ciclo < duracion);
      wrap         = cambio && (ciclo == '0) && (ciclo_prev == duracion - 1'b1);
      violacion    = cambio && !incremento && !wrap;
   end

endmodule

// File: rtl/ciclo_esclavo.sv
// Controller for the ciclo step bus: enables the master, strobes each accepted
// step, counts revolutions and reports busy/done/error status.
module ciclo_esclavo
   import ciclo_esclavo_pkg::*;
#(
   parameter int unsigned W_CICLO = 6,
   parameter int unsigned W_REP   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [W_CICLO-1:0] duracion,
   input  logic [W_REP-1:0]   repeticiones,
   input  logic [W_CICLO-1:0] ciclo,
   output logic               EN_ciclo,
   output logic [W_CICLO-1:0] duracion_out,
   output logic [W_CICLO-1:0] paso,
   output logic               paso_valido,
   output logic [W_REP-1:0]   vuelta,
   output logic               busy,
   output logic               done,
   output logic               error
);

   estado_t            estado, estado_sig;
   logic [W_REP-1:0]   rep_lat, rep_sig;
   logic [W_CICLO-1:0] dur_sig, paso_sig;
   logic [W_REP-1:0]   vuelta_sig, vuelta_inc;
   logic               pv_sig, done_sig, error_sig, activo;
   logic               limpiar, cargar;
   logic               incremento, wrap, violacion;

   detector_paso #(.W_CICLO(W_CICLO)) u_detector (
      .clk        (clk),
      .reset      (reset),
      .limpiar    (limpiar),
      .cargar     (cargar),
      .ciclo      (ciclo),
      .duracion   (duracion_out),
      .incremento (incremento),
      .wrap       (wrap),
      .violacion  (violacion)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado       <= IDLE;
         EN_ciclo     <= 1'b0;
         busy         <= 1'b0;
         paso_valido  <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         paso         <= '0;
         vuelta       <= '0;
         duracion_out <= '0;
         rep_lat      <= '0;
      end else begin
         estado       <= estado_sig;
         EN_ciclo     <= activo;
         busy         <= activo;
         paso_valido  <= pv_sig;
         done         <= done_sig;
         error        <= error_sig;
         paso         <= paso_sig;
         vuelta       <= vuelta_sig;
         duracion_out <= dur_sig;
         rep_lat      <= rep_sig;
      end
   end

   // Outputs are registered from next-state values so EN_ciclo/busy track the
   // state being entered, letting the final wrap, done and EN_ciclo fall share an edge.
   always_comb begin
      estado_sig = estado;
      paso_sig   = paso;
      pv_sig     = 1'b0;
      vuelta_sig = vuelta;
      done_sig   = 1'b0;
      error_sig  = error;
      dur_sig    = duracion_out;
      rep_sig    = rep_lat;
      limpiar    = 1'b0;
      cargar     = 1'b0;
      vuelta_inc = (vuelta == '1) ? vuelta : vuelta + 1'b1;

      case (estado)
         IDLE: begin
            if (start && !abort) begin
               if ((duracion < W_CICLO'(DURACION_MIN)) || (repeticiones == '0)) begin
                  error_sig = 1'b1;
               end else begin
                  dur_sig    = duracion;
                  rep_sig    = repeticiones;
                  error_sig  = 1'b0;
                  vuelta_sig = '0;
                  paso_sig   = '0;
                  limpiar    = 1'b1;
                  estado_sig = ARRANQUE;
               end
            end
         end
         ARRANQUE: begin
            estado_sig = abort ? IDLE : CORRIENDO;
         end
         CORRIENDO: begin
            if (abort) begin
               estado_sig = IDLE;
            end else if (incremento) begin
               paso_sig = ciclo;
               pv_sig   = 1'b1;
               cargar   = 1'b1;
            end else if (wrap) begin
               paso_sig   = '0;
               pv_sig     = 1'b1;
               cargar     = 1'b1;
               vuelta_sig = vuelta_inc;
               if (vuelta_inc == rep_lat) begin
                  done_sig   = 1'b1;
                  estado_sig = FIN;
               end
            end else if (violacion) begin
               error_sig  = 1'b1;
               estado_sig = IDLE;
            end
         end
         FIN: begin
            estado_sig = IDLE;
         end
         default: begin
            estado_sig = IDLE;
         end
      endcase

      activo = (estado_sig == ARRANQUE) || (estado_sig == CORRIENDO);
   end

endmodule

// File: tb/tb_ciclo_esclavo.sv
// Bench for ciclo_esclavo: behavioural ciclo master, table of run configurations
// and a scoreboard of expected steps consumed on every paso_valido.
module tb_ciclo_esclavo;
   import ciclo_esclavo_pkg::*;

   logic       clk, reset, start, abort;
   logic [5:0] duracion, ciclo, duracion_out, paso;
   logic [3:0] repeticiones, vuelta;
   logic       EN_ciclo, paso_valido, busy, done, error;

   ciclo_esclavo #(.W_CICLO(6), .W_REP(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .duracion     (duracion),
      .repeticiones (repeticiones),
      .ciclo        (ciclo),
      .EN_ciclo     (EN_ciclo),
      .duracion_out (duracion_out),
      .paso         (paso),
      .paso_valido  (paso_valido),
      .vuelta       (vuelta),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Behavioural master: one step every TIEMPO clocks while enabled, optional 2->3 skip.
   logic       salto_malo = 1'b0;
   int         tmr;
   logic [6:0] sig_m;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ciclo <= '0;
         tmr   <= 0;
      end else if (!EN_ciclo) begin
         ciclo <= '0;
         tmr   <= 0;
      end else if (tmr == int'(TIEMPO) - 1) begin
         tmr   <= 0;
         sig_m = {1'b0, ciclo} + 7'd1;
         if (sig_m == {1'b0, duracion_out})
            ciclo <= '0;
         else if (salto_malo && sig_m == 7'd2)
            ciclo <= 6'd3;
         else
            ciclo <= sig_m[5:0];
      end else begin
         tmr <= tmr + 1;
      end
   end

   typedef struct {
      logic [5:0] paso;
      logic       ultimo;
   } esp_t;
   esp_t q[$];
   esp_t e_mon;
   int   pulsos = 0;
   int   dones  = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (paso_valido) begin
            pulsos++;
            check("scoreboard has entry", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e_mon = q.pop_front();
               check("paso value", int'(paso), int'(e_mon.paso));
               check("done vs last step", int'(done), int'(e_mon.ultimo));
            end
         end
         if (done) begin
            dones++;
            check("done with paso_valido", int'(paso_valido), 1);
         end
      end
   end

   function automatic void push_run(input logic [5:0] d, input logic [3:0] r);
      for (int unsigned v = 0; v < r; v++) begin
         for (int unsigned s = 1; s <= d; s++) begin
            esp_t e;
            e.paso   = (s == d) ? 6'd0 : 6'(s);
            e.ultimo = (s == d) && (v == r - 1);
            q.push_back(e);
         end
      end
   endfunction

   int p0, d0;

   task automatic start_run(input logic [5:0] d, input logic [3:0] r);
      logic valido;
      valido = (d >= 6'd2) && (r != 4'd0);
      p0 = pulsos;
      d0 = dones;
      duracion     = d;
      repeticiones = r;
      start        = 1'b1;
      if (valido) push_run(d, r);
      @(negedge clk);
      start = 1'b0;
      check("EN_ciclo after start", int'(EN_ciclo), int'(valido));
      check("busy after start", int'(busy), int'(valido));
   endtask

   task automatic finish_run(input logic [5:0] d, input logic [3:0] r,
                             input logic exp_err, input logic [3:0] exp_vuelta);
      int budget;
      logic valido;
      valido = (d >= 6'd2) && (r != 4'd0);
      budget = int'(d) * int'(r) * int'(TIEMPO) + 200;
      while (busy && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("run completes in budget", int'(busy), 0);
      repeat (3) @(negedge clk);
      check("EN_ciclo low after run", int'(EN_ciclo), 0);
      check("error after run", int'(error), int'(exp_err));
      check("vuelta after run", int'(vuelta), int'(exp_vuelta));
      check("paso_valido count", pulsos - p0, valido ? int'(d) * int'(r) : 0);
      check("done count", dones - d0, int'(valido));
      check("scoreboard drained", q.size(), 0);
      if (valido) begin
         check("duracion_out latched", int'(duracion_out), int'(d));
         check("paso after final wrap", int'(paso), 0);
      end
   endtask

   typedef struct {
      logic [5:0] d;
      logic [3:0] r;
      logic       exp_err;
      logic [3:0] exp_vuelta;
   } vec_t;

   initial begin
      vec_t vt[8];
      int   budget;

      vt[0] = '{6'd4,  4'd2,  1'b0, 4'd2};
      vt[1] = '{6'd1,  4'd3,  1'b1, 4'd2};
      vt[2] = '{6'd6,  4'd0,  1'b1, 4'd2};
      vt[3] = '{6'd2,  4'd1,  1'b0, 4'd1};
      vt[4] = '{6'd3,  4'd3,  1'b0, 4'd3};
      vt[5] = '{6'd0,  4'd5,  1'b1, 4'd3};
      vt[6] = '{6'd2,  4'd15, 1'b0, 4'd15};
      vt[7] = '{6'd63, 4'd1,  1'b0, 4'd1};

      reset = 1'b1; start = 1'b0; abort = 1'b0;
      duracion = '0; repeticiones = '0;
      repeat (2) @(negedge clk);
      check("reset EN_ciclo", int'(EN_ciclo), 0);
      check("reset busy", int'(busy), 0);
      check("reset error", int'(error), 0);
      check("reset vuelta", int'(vuelta), 0);
      check("reset duracion_out", int'(duracion_out), 0);
      reset = 1'b0;
      @(negedge clk);

      for (int unsigned i = 0; i < 8; i++) begin
         start_run(vt[i].d, vt[i].r);
         finish_run(vt[i].d, vt[i].r, vt[i].exp_err, vt[i].exp_vuelta);
      end

      // Master skips 1 -> 3: error one cycle after the bad index appears.
      salto_malo = 1'b1;
      start_run(6'd6, 4'd1);
      budget = 6 * int'(TIEMPO) + 100;
      while (ciclo != 6'd3 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("bad jump seen", int'(ciclo), 3);
      check("error not yet set", int'(error), 0);
      @(negedge clk);
      check("error after jump", int'(error), 1);
      check("EN_ciclo after jump", int'(EN_ciclo), 0);
      check("busy after jump", int'(busy), 0);
      check("paso keeps last step", int'(paso), 1);
      check("no done on violation", dones - d0, 0);
      salto_malo = 1'b0;
      q.delete();
      repeat (5) @(negedge clk);

      // Abort during step 2.
      start_run(6'd5, 4'd3);
      budget = 3 * int'(TIEMPO) + 100;
      while (!(paso_valido && paso == 6'd2) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("reached step 2", int'(paso), 2);
      check("error cleared by start", int'(error), 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      q.delete();
      check("abort EN_ciclo", int'(EN_ciclo), 0);
      check("abort busy", int'(busy), 0);
      check("abort vuelta", int'(vuelta), 0);
      check("abort error", int'(error), 0);
      repeat (2 * int'(TIEMPO)) @(negedge clk);
      check("no pulses after abort", pulsos - p0, 2);
      check("no done after abort", dones - d0, 0);

      // start and abort together in IDLE: abort wins.
      duracion = 6'd3; repeticiones = 4'd1; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start+abort busy", int'(busy), 0);
      check("start+abort EN_ciclo", int'(EN_ciclo), 0);
      check("start+abort duracion_out", int'(duracion_out), 5);

      // start while busy is ignored.
      start_run(6'd4, 4'd1);
      repeat (10) @(negedge clk);
      duracion = 6'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy start ignored", int'(duracion_out), 4);
      check("still busy", int'(busy), 1);
      finish_run(6'd4, 4'd1, 1'b0, 4'd1);

      // Asynchronous reset mid-run, then a fresh short run.
      start_run(6'd4, 4'd2);
      budget = 4 * int'(TIEMPO) + 100;
      while ((pulsos - p0) < 3 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("pulses before reset", pulsos - p0, 3);
      #2 reset = 1'b1;
      #1;
      check("async reset EN_ciclo", int'(EN_ciclo), 0);
      check("async reset busy", int'(busy), 0);
      check("async reset paso", int'(paso), 0);
      check("async reset vuelta", int'(vuelta), 0);
      check("async reset duracion_out", int'(duracion_out), 0);
      check("async reset paso_valido", int'(paso_valido), 0);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      @(negedge clk);
      start_run(6'd3, 4'd1);
      finish_run(6'd3, 4'd1, 1'b0, 4'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
